// File: rtl/phase_wrap_pkg.sv
// Default widths shared by the phase wrapper and anything that instantiates it.
package phase_wrap_pkg;

   localparam int WIN_DEFAULT    = 17;
   localparam int WPI2IN_DEFAULT = 1;
   localparam int WOUT_DEFAULT   = 25;

endpackage

// File: rtl/phase_wrap.sv
// Phase wrapper: splits an unwrapped phase into a wrapped phase in
// [-half turn, half turn) plus a whole-turn count, after subtracting a
// programmable offset. It also flags input steps of half a turn or more,
// since a downstream unwrapper cannot resolve those unambiguously.
module phase_wrap
   import phase_wrap_pkg::*;
#(
   parameter int WIN    = WIN_DEFAULT,
   parameter int WPI2IN = WPI2IN_DEFAULT,
   parameter int WOUT   = WOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sync_in,
   input  logic signed [WOUT-1:0]   d_in,
   input  logic                     offset_set,
   input  logic signed [WOUT-1:0]   offset_value,
   input  logic                     err_clear,
   output logic                     sync_out,
   output logic signed [WIN-1:0]    d_out,
   output logic signed [WOUT-WIN+WPI2IN-2:0] wrapout,
   output logic                     step_err
);

   // One full turn is 2^T LSB; the turn count takes the remaining bits.
   localparam int T  = WIN - WPI2IN + 1;
   localparam int WW = WOUT - T;

   // Half a turn, at the width of the step difference.
   localparam logic signed [WOUT:0] HALF_POS = $signed({{WOUT{1'b0}}, 1'b1}) <<< (T - 1);
   localparam logic signed [WOUT:0] HALF_NEG = -HALF_POS;

   // Stage 1 state
   logic signed [WOUT-1:0] p1_q, p1_d;
   logic signed [WOUT:0]   diff_q, diff_d;
   logic signed [WOUT-1:0] prev_q;
   logic signed [WOUT-1:0] off_q;
   logic                   sync1_q;
   logic                   chk1_q;
   logic                   first_q;

   // Stage 2 state
   logic signed [WIN-1:0]  d_out_q, d_out_d;
   logic signed [WW-1:0]   wrap_q, wrap_d;
   logic                   sync_out_q;
   logic                   err_q, err_d;
   logic signed [T-1:0]    lo_s;
   logic                   step_viol;

   // Stage 1 next-state: offset removal (wraps at WOUT) and one-bit-wider step size.
   always_comb begin
      p1_d   = d_in - off_q;
      diff_d = {d_in[WOUT-1], d_in} - {prev_q[WOUT-1], prev_q};
   end

   // Stage 1 registers: capture the sample, remember it for the next step, tag first sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_q    <= '0;
         diff_q  <= '0;
         prev_q  <= '0;
         off_q   <= '0;
         sync1_q <= 1'b0;
         chk1_q  <= 1'b0;
         first_q <= 1'b1;
      end else begin
         sync1_q <= sync_in;
         if (sync_in) begin
            p1_q    <= p1_d;
            diff_q  <= diff_d;
            prev_q  <= d_in;
            chk1_q  <= ~first_q;
            first_q <= 1'b0;
         end
         // Loaded after the same-edge sample has already used the old offset.
         if (offset_set) begin
            off_q <= offset_value;
         end
      end
   end

   // Stage 2 next-state: split into wrapped phase and turn count; a low part of
   // exactly half a turn becomes the negative extreme and bumps the turn count.
   always_comb begin
      lo_s      = p1_q[T-1:0];
      d_out_d   = WIN'(lo_s);
      wrap_d    = p1_q[WOUT-1:T] + WW'(p1_q[T-1]);
      step_viol = sync1_q && chk1_q && ((diff_q >= HALF_POS) || (diff_q <= HALF_NEG));
      err_d     = err_q;
      if (step_viol) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end
   end

   // Stage 2 registers: outputs update only on a strobe and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out_q    <= '0;
         wrap_q     <= '0;
         sync_out_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sync_out_q <= sync1_q;
         err_q      <= err_d;
         if (sync1_q) begin
            d_out_q <= d_out_d;
            wrap_q  <= wrap_d;
         end
      end
   end

   assign sync_out = sync_out_q;
   assign d_out    = d_out_q;
   assign wrapout  = wrap_q;
   assign step_err = err_q;

endmodule

// File: tb/tb_phase_wrap.sv
// Bench for phase_wrap at default widths (T=17, WW=8, WOUT=25): directed
// vectors with literal expectations plus a per-cycle reference model.
module tb_phase_wrap;

   localparam int WIN  = 17;
   localparam int WOUT = 25;
   localparam int WW   = 8;
   localparam longint TURN = 131072;
   localparam longint HALF = 65536;
   localparam longint MODN = 33554432;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    sync_in;
   logic signed [WOUT-1:0]  d_in;
   logic                    offset_set;
   logic signed [WOUT-1:0]  offset_value;
   logic                    err_clear;
   logic                    sync_out;
   logic signed [WIN-1:0]   d_out;
   logic signed [WW-1:0]    wrapout;
   logic                    step_err;

   int n_chk  = 0;
   int n_fail = 0;

   phase_wrap dut (
      .clk(clk), .rst(rst), .sync_in(sync_in), .d_in(d_in),
      .offset_set(offset_set), .offset_value(offset_value), .err_clear(err_clear),
      .sync_out(sync_out), .d_out(d_out), .wrapout(wrapout), .step_err(step_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic
   function automatic longint wrapn(input longint x);
      longint m;
      m = x % MODN;
      if (m < 0) m += MODN;
      if (m >= MODN / 2) m -= MODN;
      return m;
   endfunction

   function automatic longint wrapd(input longint v);
      longint m;
      m = (v + HALF) % TURN;
      if (m < 0) m += TURN;
      return m - HALF;
   endfunction

   function automatic longint wrapw(input longint v);
      longint m;
      m = ((v - wrapd(v)) / TURN) % 256;
      if (m < 0) m += 256;
      if (m >= 128) m -= 256;
      return m;
   endfunction

   // Reference model state
   typedef struct {
      int     due;
      longint v;
      bit     viol;
   } ent_t;

   ent_t   q[$];
   ent_t   e;
   int     cyc     = 0;
   bit     m_so    = 0;
   longint m_d     = 0;
   longint m_w     = 0;
   longint m_v     = 0;
   bit     m_err   = 0;
   bit     m_first = 1;
   longint m_prev  = 0;
   longint m_off   = 0;
   bit     setv;
   longint dl;
   longint dif;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            m_so = 0; m_d = 0; m_w = 0; m_v = 0; m_err = 0;
            m_first = 1; m_prev = 0; m_off = 0;
         end else begin
            cyc++;
            setv = 0;
            m_so = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
               e    = q.pop_front();
               m_so = 1;
               m_v  = e.v;
               m_d  = wrapd(e.v);
               m_w  = wrapw(e.v);
               setv = e.viol;
            end
            if (setv) m_err = 1;
            else if (err_clear) m_err = 0;
            if (sync_in) begin
               dl  = longint'(d_in);
               dif = dl - m_prev;
               e.due  = cyc + 1;
               e.v    = wrapn(dl - m_off);
               e.viol = !m_first && (dif >= HALF || dif <= -HALF);
               q.push_back(e);
               m_prev  = dl;
               m_first = 0;
            end
            if (offset_set) m_off = longint'(offset_value);
         end
      end
   end

   // Per-cycle compare against the model, including the turn identity.
   initial begin
      forever begin
         @(negedge clk);
         chk("sync_out", longint'(sync_out), longint'(m_so));
         chk("d_out", longint'(d_out), m_d);
         chk("wrapout", longint'(wrapout), m_w);
         chk("step_err", longint'(step_err), longint'(m_err));
         if (sync_out) begin
            chk("identity", ((longint'(wrapout) * TURN) + longint'(d_out)) & (MODN - 1),
                m_v & (MODN - 1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Strobe one sample, wait until its outputs are visible, check them.
   task automatic send_chk(input longint din, input longint ed, input longint ew);
      sync_in = 1'b1;
      d_in    = WOUT'(din);
      step();
      sync_in = 1'b0;
      step();
      chk("lit_sync_out", longint'(sync_out), 1);
      chk("lit_d_out", longint'(d_out), ed);
      chk("lit_wrapout", longint'(wrapout), ew);
   endtask

   initial begin
      rst = 1'b1; sync_in = 1'b0; d_in = '0; offset_set = 1'b0;
      offset_value = '0; err_clear = 1'b0;
      step(); step();
      chk("rst_d_out", longint'(d_out), 0);
      chk("rst_wrapout", longint'(wrapout), 0);
      chk("rst_sync_out", longint'(sync_out), 0);
      chk("rst_step_err", longint'(step_err), 0);
      rst = 1'b0;
      step();

      // Basic split and hold between strobes
      send_chk(70000, -61072, 1);
      step();
      chk("hold_sync_out", longint'(sync_out), 0);
      chk("hold_d_out", longint'(d_out), -61072);
      chk("hold_wrapout", longint'(wrapout), 1);

      // Half-turn boundaries
      send_chk(65536, -65536, 1);
      send_chk(-65536, -65536, 0);

      // Reset in the middle of a back-to-back burst
      sync_in = 1'b1; d_in = 25'sd1000; step();
      d_in = 25'sd2000; step();
      rst = 1'b1;
      #1;
      chk("mid_rst_d_out", longint'(d_out), 0);
      chk("mid_rst_wrapout", longint'(wrapout), 0);
      chk("mid_rst_sync_out", longint'(sync_out), 0);
      chk("mid_rst_step_err", longint'(step_err), 0);
      step();
      sync_in = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_sync_out1", longint'(sync_out), 0);
      step();
      chk("post_rst_sync_out2", longint'(sync_out), 0);

      // Step check: first sample suppressed, then half-turn limit
      send_chk(0, 0, 0);
      chk("err_first", longint'(step_err), 0);
      send_chk(65535, 65535, 0);
      chk("err_small", longint'(step_err), 0);
      send_chk(-70000, 61072, -1);
      chk("err_big", longint'(step_err), 1);
      err_clear = 1'b1; step(); err_clear = 1'b0;
      chk("err_cleared", longint'(step_err), 0);
      sync_in = 1'b1; d_in = 25'sd70000; step();
      sync_in = 1'b0; err_clear = 1'b1; step();
      err_clear = 1'b0;
      chk("err_set_wins", longint'(step_err), 1);
      chk("err_set_d_out", longint'(d_out), -61072);

      // Offset load: same-edge sample sees the old offset
      offset_set = 1'b1; offset_value = 25'sd1000; sync_in = 1'b1; d_in = 25'sd500;
      step();
      offset_set = 1'b0;
      step();
      sync_in = 1'b0;
      chk("off_old_d_out", longint'(d_out), 500);
      chk("off_old_wrapout", longint'(wrapout), 0);
      step();
      chk("off_new_d_out", longint'(d_out), -500);
      chk("off_new_wrapout", longint'(wrapout), 0);
      step();

      // Random back-to-back sweep over the full input range
      for (int i = 0; i < 300; i++) begin
         sync_in      = ($urandom_range(0, 3) != 0);
         d_in         = WOUT'($urandom);
         offset_set   = ($urandom_range(0, 15) == 0);
         offset_value = WOUT'($urandom);
         err_clear    = ($urandom_range(0, 7) == 0);
         step();
      end
      sync_in = 1'b0; offset_set = 1'b0; err_clear = 1'b0;
      step(); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
